mib_input_buffer: RTL and testbench
===================================

# mib_input_buffer

Receiving end of the instruction input interface that the output demux drives. Each processing-unit input buffer accepts move and immediate instructions and queues them in program order. For a move, it fetches the operand from the interconnect source named by `move_from`. It then presents operands one at a time to the processing unit over a valid/ready port.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of immediates and operand data
- `ADDR_WIDTH`, 4, width of `move_from` (interconnect source address)
- `DEPTH`, 4, instruction queue entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `move_from`  in  ADDR_WIDTH  source address of a move instruction
- `move_valid`  in  1  move instruction present
- `immediate`  in  DATA_WIDTH  immediate operand
- `immediate_valid`  in  1  immediate instruction present
- `move_ack`  out  1  combinational; acknowledges every instruction presented this cycle (the shared ack for move and immediate)
- `src_addr`  out  ADDR_WIDTH  address of the source being fetched
- `src_req`  out  1  fetch request, held until `src_valid`
- `src_data`  in  DATA_WIDTH  fetched operand
- `src_valid`  in  1  `src_data` valid; meaningful only while `src_req`=1
- `out_data`  out  DATA_WIDTH  operand to the processing unit
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  processing unit consumes operand

## Operation
- Queue: circular buffer of `DEPTH` entries. Each entry is {is_imm, payload}; payload is the immediate, or `move_from` zero-extended. Write and read pointers wrap modulo `DEPTH`. Occupancy counter `count` ranges 0..DEPTH.
- `need` is `move_valid` + `immediate_valid` (0, 1 or 2).
- `move_ack` = (`need`>0) && (DEPTH−`count` ≥ `need`), evaluated with the current cycle's pop not credited.
- Acceptance happens on a clock edge with `move_ack`=1.
  - Both valid at once: the immediate is written first, the move second. Both are accepted or neither.
  - The queue is never overfilled. `move_ack`=0 whenever the queue is full.
- FSM states IDLE, FETCH, OUT. Reset state is IDLE.
  - IDLE, queue empty: stay in IDLE.
  - IDLE, head is an immediate: load `out_data` with the payload, pop, go to OUT.
  - IDLE, head is a move: go to FETCH. No pop yet.
  - FETCH: `src_req`=1 and `src_addr`=head address, held stable. On `src_valid`: capture `src_data` into `out_data`, pop, go to OUT.
  - OUT: `out_valid`=1. On `out_ready`, go to IDLE.
- `src_req` is high only in FETCH. `out_valid` is high only in OUT.
- In the same cycle, a push and a pop both update `count` (net change = pushes − pops).
- `src_valid` outside FETCH is ignored.
- Values on `move_from` and `immediate` are don't-care while their valid is low.

## Timing
- Reset (asynchronous, immediate): `count`=0, pointers=0, state=IDLE, `src_req`=0, `src_addr`=0, `out_valid`=0, `out_data`=0. `move_ack` follows its equation, so it is 0 when no instruction is presented.
- Reset mid-FETCH or mid-OUT: the request and output drop at once, and queued instructions are discarded.
- Immediate into an empty, idle buffer:
  - accepted at edge 0, state IDLE in cycle 1;
  - operand loaded at edge 1, `out_valid`=1 from cycle 2.
- Move into an empty, idle buffer:
  - FETCH from cycle 2, with `src_req` high in cycle 2;
  - if `src_valid` arrives in cycle 2, `out_valid`=1 from cycle 3;
  - each cycle of `src_valid` delay adds one cycle.
- Throughput: at most one operand per 2 cycles, because OUT always returns through IDLE.
- `out_data` and `src_addr` are stable while their valid/req is high.

## Test plan
- Reset, then `immediate`=0x0000_00AA with `immediate_valid`=1 for one cycle → `move_ack`=1 that cycle; `out_valid`=1 with `out_data`=0xAA two cycles later; with `out_ready`=1, `out_valid` drops the next cycle.
- Move with `move_from`=4'd7 → `src_req`=1 and `src_addr`=7 two cycles after acceptance. Hold `src_valid`=0 for 3 cycles, then `src_data`=0x1234 → `src_req` held stable throughout; `out_data`=0x1234 the next cycle.
- `out_ready`=0, push 5 immediates back to back (DEPTH=4, first already popped to OUT) → first 5 acked; 6th sees `move_ack`=0 until `out_ready` frees space; outputs appear in push order.
- Simultaneous `immediate`=0x55 and move from 3 with 1 free slot → `move_ack`=0; after space frees, both acked in one cycle; output order is 0x55, then the fetched data from source 3.
- Assert `resetn`=0 during FETCH with 2 entries queued → `src_req`/`out_valid` drop that cycle; after release, no output appears without new input.
- Stream 10 alternating immediates/moves with random `out_ready`/`src_valid` delays (pointer wrap) → outputs match the scoreboard in order, with no loss or duplication.

Source files
------------

// File: rtl/mib_input_buffer.sv
// Processing-unit input buffer: queues move/immediate instructions in program order,
// fetches move operands from the interconnect and hands operands out over valid/ready.
module mib_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] move_from,
  input  logic                  move_valid,
  input  logic [DATA_WIDTH-1:0] immediate,
  input  logic                  immediate_valid,
  output logic                  move_ack,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  is_imm;
    logic [DATA_WIDTH-1:0] payload;
  } entry_t;

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] mv_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] need;
  logic [CW-1:0] free;
  logic          pop;
  state_t        state;

  // NOTE: every variable gets a value before any condition, so no latch can be inferred.
  always_comb begin
    need     = CW'(move_valid) + CW'(immediate_valid);
    free     = CW'(DEPTH) - count;
    move_ack = (need != '0) && (free >= need);
  end

  // An immediate presented alongside a move takes the first slot.
  assign mv_ptr = immediate_valid ? wr_ptr + PW'(1) : wr_ptr;
  assign head   = mem[rd_ptr];
  assign pop    = ((state == IDLE) && (count != '0) && head.is_imm) ||
                  ((state == FETCH) && src_valid);

  // NOTE: queue storage has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (move_ack) begin
      if (immediate_valid) mem[wr_ptr] <= '{is_imm: 1'b1, payload: immediate};
      if (move_valid)      mem[mv_ptr] <= '{is_imm: 1'b0, payload: DATA_WIDTH'(move_from)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (move_ack) wr_ptr <= wr_ptr + PW'(need);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      count <= count + (move_ack ? need : '0) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      src_req   <= 1'b0;
      src_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            if (head.is_imm) begin
              out_data  <= head.payload;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              src_addr <= head.payload[ADDR_WIDTH-1:0];
              src_req  <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (src_valid) begin
            out_data  <= src_data;
            src_req   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          src_req   <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mib_input_buffer.sv
// Directed bench for mib_input_buffer: a per-cycle vector table for the basic paths, then
// hand-written sequences for full queue, paired instructions, reset mid-fetch and streaming.
module tb_mib_input_buffer;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] move_from;
  logic          move_valid;
  logic [DW-1:0] immediate;
  logic          immediate_valid;
  logic          move_ack;
  logic [AW-1:0] src_addr;
  logic          src_req;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  // Source port is driven either directly by the vectors or by the model responder.
  logic          tb_src_valid, resp_valid, resp_en, mon_en, rand_rdy;
  logic [DW-1:0] tb_src_data, resp_data;
  int            wait_cnt;
  logic          last_req;
  logic [AW-1:0] last_addr;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb[$];

  assign src_valid = resp_en ? resp_valid : tb_src_valid;
  assign src_data  = resp_en ? resp_data  : tb_src_data;

  mib_input_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .move_from       (move_from),
    .move_valid      (move_valid),
    .immediate       (immediate),
    .immediate_valid (immediate_valid),
    .move_ack        (move_ack),
    .src_addr        (src_addr),
    .src_req         (src_req),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] imm;
    logic          mv;
    logic [AW-1:0] from;
    logic          sv;
    logic [DW-1:0] sd;
    logic          rdy;
    logic          e_ack;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          e_ov;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] imm, input logic mv,
                              input logic [AW-1:0] from, input logic sv, input logic [DW-1:0] sd,
                              input logic rdy, input logic e_ack, input logic e_req,
                              input logic [AW-1:0] e_addr, input logic e_ov,
                              input logic [DW-1:0] e_od);
    vec_t v;
    v.iv = iv; v.imm = imm; v.mv = mv; v.from = from; v.sv = sv; v.sd = sd; v.rdy = rdy;
    v.e_ack = e_ack; v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_od = e_od;
    return v;
  endfunction

  function automatic logic [DW-1:0] src_model(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output scoreboard and interconnect source model, evaluated on the falling edge.
  task automatic half_cycle_models();
    if (mon_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no output", out_data);
      end else begin
        check("out_order", out_data, sb.pop_front());
      end
    end
    if (resp_en && src_req) begin
      if (last_req) check("src_addr_stable", DW'(src_addr), DW'(last_addr));
      last_req  = 1'b1;
      last_addr = src_addr;
      if (wait_cnt == 0) begin
        resp_valid = 1'b1;
        resp_data  = src_model(src_addr);
      end else begin
        wait_cnt--;
        resp_valid = 1'b0;
      end
    end else begin
      last_req   = 1'b0;
      resp_valid = 1'b0;
      wait_cnt   = int'($urandom_range(0, 3));
    end
  endtask

  // One clock: models at negedge, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    half_cycle_models();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present an instruction until acked (bounded), record the expected operands, then drop it.
  task automatic send(input logic iv, input logic [DW-1:0] iw, input logic mv,
                      input logic [AW-1:0] mf, input int budget, input string name);
    int c = 0;
    immediate_valid = iv;
    immediate       = iw;
    move_valid      = mv;
    move_from       = mf;
    #1;
    while (!move_ack && c < budget) begin
      tick();
      c++;
      #1;
    end
    check(name, DW'(move_ack), DW'(1));
    if (move_ack) begin
      if (iv) sb.push_back(iw);
      if (mv) sb.push_back(src_model(mf));
    end
    tick();
    immediate_valid = 1'b0;
    move_valid      = 1'b0;
  endtask

  task automatic expect_nack(input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      #1;
      check(name, DW'(move_ack), DW'(0));
      tick();
    end
  endtask

  task automatic drain(input int budget, input string name);
    int c = 0;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check(name, DW'(sb.size()), DW'(0));
    tick();
    tick();
    check({name, "_idle"}, DW'(out_valid), DW'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; move_from = '0; move_valid = 1'b0; immediate = '0; immediate_valid = 1'b0;
    tb_src_valid = 1'b0; tb_src_data = '0; out_ready = 1'b0;
    resp_en = 1'b0; mon_en = 1'b0; rand_rdy = 1'b0; resp_valid = 1'b0; resp_data = '0;
    wait_cnt = 0; last_req = 1'b0; last_addr = '0;

    //           iv imm        mv from sv sd          rdy ack req addr ov od
    tbl[0]  = mk(1, 32'hAA,    0, 0,   0, 0,          0,  1,  0,  0,   0, 0);
    tbl[1]  = mk(0, 0,         0, 0,   0, 0,          0,  0,  0,  0,   0, 0);
    tbl[2]  = mk(0, 0,         0, 0,   0, 0,          1,  0,  0,  0,   1, 32'hAA);
    tbl[3]  = mk(0, 0,         1, 7,   0, 0,          0,  1,  0,  0,   0, 0);
    tbl[4]  = mk(0, 0,         0, 0,   0, 0,          0,  0,  0,  0,   0, 0);
    tbl[5]  = mk(0, 0,         0, 0,   0, 0,          0,  0,  1,  7,   0, 0);
    tbl[6]  = mk(0, 0,         0, 0,   0, 0,          0,  0,  1,  7,   0, 0);
    tbl[7]  = mk(0, 0,         0, 0,   0, 0,          0,  0,  1,  7,   0, 0);
    tbl[8]  = mk(0, 0,         0, 0,   1, 32'h1234,   0,  0,  1,  7,   0, 0);
    tbl[9]  = mk(0, 0,         0, 0,   0, 0,          0,  0,  0,  0,   1, 32'h1234);
    tbl[10] = mk(0, 0,         0, 0,   0, 0,          1,  0,  0,  0,   1, 32'h1234);
    tbl[11] = mk(0, 0,         0, 0,   1, 32'hDEAD,   0,  0,  0,  0,   0, 0);
    tbl[12] = mk(0, 0,         0, 0,   0, 0,          0,  0,  0,  0,   0, 0);
    tbl[13] = mk(0, 0,         0, 0,   0, 0,          0,  0,  0,  0,   0, 0);

    #12;
    check("rst_src_req",   DW'(src_req),   DW'(0));
    check("rst_src_addr",  DW'(src_addr),  DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data",  out_data,       DW'(0));
    check("rst_move_ack",  DW'(move_ack),  DW'(0));
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      immediate_valid = tbl[i].iv;
      immediate       = tbl[i].imm;
      move_valid      = tbl[i].mv;
      move_from       = tbl[i].from;
      tb_src_valid    = tbl[i].sv;
      tb_src_data     = tbl[i].sd;
      out_ready       = tbl[i].rdy;
      #1;
      check($sformatf("v%0d_ack", i),       DW'(move_ack),  DW'(tbl[i].e_ack));
      check($sformatf("v%0d_src_req", i),   DW'(src_req),   DW'(tbl[i].e_req));
      if (tbl[i].e_req) check($sformatf("v%0d_src_addr", i), DW'(src_addr), DW'(tbl[i].e_addr));
      check($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].e_ov));
      if (tbl[i].e_ov) check($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      tick();
    end
    immediate_valid = 1'b0; move_valid = 1'b0; tb_src_valid = 1'b0; out_ready = 1'b0;

    // Full queue: five immediates fit (one already in OUT), the sixth waits for space.
    mon_en = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, DW'(32'h10 + i), 1'b0, '0, 0, "full_push_ack");
    immediate_valid = 1'b1;
    immediate       = 32'h15;
    expect_nack(3, "full_nack");
    out_ready = 1'b1;
    send(1'b1, 32'h15, 1'b0, '0, 10, "full_sixth_ack");
    drain(100, "full_drain");

    // Paired immediate+move with a single free slot: refused until two slots are free.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, DW'(32'h20 + i), 1'b0, '0, 0, "pair_fill_ack");
    immediate_valid = 1'b1;
    immediate       = 32'h55;
    move_valid      = 1'b1;
    move_from       = 4'd3;
    expect_nack(2, "pair_nack");
    out_ready = 1'b1;
    send(1'b1, 32'h55, 1'b1, 4'd3, 10, "pair_ack");
    drain(100, "pair_drain");

    // Reset while fetching with two entries queued.
    resp_en = 1'b0;
    tb_src_valid = 1'b0;
    out_ready = 1'b0;
    send(1'b0, '0, 1'b1, 4'd5, 0, "rst_mv_ack");
    send(1'b1, 32'h66, 1'b0, '0, 0, "rst_imm_ack");
    #1;
    check("rst_in_fetch", DW'(src_req), DW'(1));
    resetn = 1'b0;
    #1;
    check("rst_drop_src_req",   DW'(src_req),   DW'(0));
    check("rst_drop_out_valid", DW'(out_valid), DW'(0));
    check("rst_drop_src_addr",  DW'(src_addr),  DW'(0));
    sb.delete();
    tick();
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_out_valid", DW'(out_valid), DW'(0));
      check("post_rst_src_req",   DW'(src_req),   DW'(0));
    end

    // Alternating stream with random backpressure and source latency; pointers wrap.
    resp_en  = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(1'b1, DW'(32'h100 + i), 1'b0, '0, 50, "stream_imm_ack");
      else            send(1'b0, '0, 1'b1, AW'(i), 50, "stream_mv_ack");
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) tick();
    end
    drain(300, "stream_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
